sseg_scan_driver: RTL and testbench

SSEG_SCAN_DRIVER -- requirements
Module: sseg_scan_driver

---
 rtl/sseg_pkg.sv | 35 +++
 rtl/sseg_hex_decoder.sv | 42 ++++
 rtl/sseg_scan_driver.sv | 170 +++++++++++++++++
 tb/tb_sseg_scan_driver.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// sseg_pkg -- shared definitions for the seven-segment scan driver.
//
// Holds the segment-pattern type and constants used by the nibble decoder and
// by the scan driver's blanking logic. Segment bit order is {g,f,e,d,c,b,a},
// active high.
package sseg_pkg;

  localparam int SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  // All segments off. Used for blanked, disabled and blink-off digits.
  localparam seg_t SEG_BLANK = 7'h00;

  // Decimal glyphs.
  localparam seg_t SEG_0 = 7'h3F;
  localparam seg_t SEG_1 = 7'h06;
  localparam seg_t SEG_2 = 7'h5B;
  localparam seg_t SEG_3 = 7'h4F;
  localparam seg_t SEG_4 = 7'h66;
  localparam seg_t SEG_5 = 7'h6D;
  localparam seg_t SEG_6 = 7'h7D;
  localparam seg_t SEG_7 = 7'h07;
  localparam seg_t SEG_8 = 7'h7F;
  localparam seg_t SEG_9 = 7'h6F;

  // Hex glyphs A, b, C, d, E, F (only reachable when hex decoding is built in).
  localparam seg_t SEG_A = 7'h77;
  localparam seg_t SEG_B = 7'h7C;
  localparam seg_t SEG_C = 7'h39;
  localparam seg_t SEG_D = 7'h5E;
  localparam seg_t SEG_E = 7'h79;
  localparam seg_t SEG_F = 7'h71;

endpackage

// File: rtl/sseg_hex_decoder.sv
// sseg_hex_decoder -- combinational nibble to seven-segment decoder.
//
// Ports:
//   nibble_i  [3:0]  value to display
//   seg_o     [6:0]  segment pattern {g,f,e,d,c,b,a}, active high
//
// Build option: define SSEG_HEX_EN to decode nibbles 10-15 as A,b,C,d,E,F.
// Without it those nibbles decode to all segments off.
module sseg_hex_decoder
  import sseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg_t       seg_o
);

  always_comb begin
    // NOTE: default assigned before the case so every path drives seg_o and no latch is inferred.
    seg_o = SEG_BLANK;
    case (nibble_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
`ifdef SSEG_HEX_EN
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
`endif
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver -- multiplexed seven-segment display scanner.
//
// Cycles through NUM_DIGITS digits, spending SCAN_DIV clocks on each. The first
// clock of every digit slot drives all selects and segments low so the previous
// digit's pattern never ghosts onto the next one. New display data is staged in
// a pending set and committed only at the frame boundary, so one frame never
// mixes old and new digits. Digits flagged for blink alternate between lit and
// dark every BLINK_FRAMES frames.
//
// Parameters:
//   NUM_DIGITS    digit count (2..16)
//   SCAN_DIV      clocks per digit slot (>= 2)
//   BLINK_FRAMES  frames per blink half-period (>= 1)
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   digits_in    nibble i drives digit i, digit 0 in bits 3:0
//   ena_in       per-digit enable, 0 blanks the digit
//   blink_in     per-digit blink request
//   load         one-cycle strobe capturing digits_in/ena_in/blink_in
//   seg          registered segments {g,f,e,d,c,b,a}, active high
//   dig_sel      registered one-hot (or all-zero) digit select, active high
//   frame_done   registered one-cycle pulse in the first cycle of each frame
//
// Build option: SSEG_HEX_EN (applied inside sseg_hex_decoder) enables A-F glyphs.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   ena_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  input  logic                    load,
  output logic [SEG_W-1:0]        seg,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_done
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   ena;
    logic [NUM_DIGITS-1:0]   blink;
  } disp_t;

  logic [SCAN_W-1:0]     scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  disp_t                 pend_q, pend_d;
  disp_t                 act_q, act_d;
  disp_t                 load_set;
  seg_t                  seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;
  logic                  frame_done_q, frame_done_d;

  logic                  scan_wrap, idx_wrap, frame_wrap, blink_wrap;
  logic [3:0]            cur_nib;
  logic                  cur_ena, cur_blink;
  logic [NUM_DIGITS-1:0] cur_onehot;
  seg_t                  dec_seg;

  // Scan, digit and blink counters.
  always_comb begin
    scan_wrap  = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    idx_wrap   = (idx_q == IDX_W'(NUM_DIGITS - 1));
    frame_wrap = scan_wrap && idx_wrap;
    blink_wrap = (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1));

    scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);

    idx_d = idx_q;
    if (scan_wrap) idx_d = idx_wrap ? '0 : idx_q + IDX_W'(1);

    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_wrap) begin
      blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + BLINK_W'(1);
      if (blink_wrap) blink_phase_d = ~blink_phase_q;
    end

    frame_done_d = frame_wrap;
  end

  // Pending always holds the most recent load. At the frame boundary the
  // active set takes pending, or the inputs directly when a load lands on the
  // boundary cycle itself (pending would only catch that one a frame late).
  always_comb begin
    load_set.digits = digits_in;
    load_set.ena    = ena_in;
    load_set.blink  = blink_in;

    pend_d = load ? load_set : pend_q;

    act_d = act_q;
    if (frame_wrap) act_d = load ? load_set : pend_q;
  end

  // Outputs are built from next-state values so the registered seg/dig_sel
  // line up with the counters they describe, with no extra cycle of lag.
  always_comb begin
    cur_nib    = 4'h0;
    cur_ena    = 1'b0;
    cur_blink  = 1'b0;
    cur_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        cur_nib       = act_d.digits[4*i +: 4];
        cur_ena       = act_d.ena[i];
        cur_blink     = act_d.blink[i];
        cur_onehot[i] = 1'b1;
      end
    end
  end

  sseg_hex_decoder u_decoder (
    .nibble_i (cur_nib),
    .seg_o    (dec_seg)
  );

  always_comb begin
    seg_d     = SEG_BLANK;
    dig_sel_d = '0;
    // Slot count 0 is the ghosting guard: everything off for one clock.
    if (scan_cnt_d != '0) begin
      dig_sel_d = cur_onehot;
      if (cur_ena && !(cur_blink && !blink_phase_d)) seg_d = dec_seg;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q    <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      // NOTE: the display sets are plain flops, not a RAM, so they are reset; a cleared active ena keeps every digit dark until the first commit.
      pend_q        <= '0;
      act_q         <= '0;
      seg_q         <= SEG_BLANK;
      dig_sel_q     <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      pend_q        <= pend_d;
      act_q         <= act_d;
      seg_q         <= seg_d;
      dig_sel_q     <= dig_sel_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dig_sel    = dig_sel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// tb_sseg_scan_driver -- self-checking bench for sseg_scan_driver.
//
// The reference model works from absolute cycle numbers: cycle k after reset
// release lies in frame k/FRAME, digit slot (k/SCAN_DIV)%NUM_DIGITS, and slot
// position k%SCAN_DIV. Loads are logged with their cycle; a frame shows the
// last load made before that frame began. Outputs are compared every cycle
// at the falling edge.
module tb_sseg_scan_driver;

  localparam int N     = 6;
  localparam int SD    = 4;
  localparam int BF    = 2;
  localparam int FRAME = N * SD;

  logic           clk;
  logic           rst_n;
  logic [4*N-1:0] digits_in;
  logic [N-1:0]   ena_in;
  logic [N-1:0]   blink_in;
  logic           load;
  logic [6:0]     seg;
  logic [N-1:0]   dig_sel;
  logic           frame_done;

  sseg_scan_driver #(
    .NUM_DIGITS   (N),
    .SCAN_DIV     (SD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits_in  (digits_in),
    .ena_in     (ena_in),
    .blink_in   (blink_in),
    .load       (load),
    .seg        (seg),
    .dig_sel    (dig_sel),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] DIGIT_PAT [10] =
    '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
`ifdef SSEG_HEX_EN
  localparam logic [6:0] HEX_PAT [6] = '{7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
`endif

  typedef struct {
    int             cyc;
    logic [4*N-1:0] d;
    logic [N-1:0]   e;
    logic [N-1:0]   b;
  } load_rec_t;

  load_rec_t loads[$];
  int        k;
  int        n_checks;
  int        n_pass;

  function automatic logic [6:0] glyph(input int v);
    if (v < 10) return DIGIT_PAT[v];
`ifdef SSEG_HEX_EN
    return HEX_PAT[v-10];
`else
    return 7'h00;
`endif
  endfunction

  function automatic logic [4*N-1:0] rnd_d();
    logic [31:0] r;
    r = $urandom;
    return r[4*N-1:0];
  endfunction

  function automatic logic [N-1:0] rnd_m();
    logic [31:0] r;
    r = $urandom;
    return r[N-1:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Expected outputs for cycle kk.
  function automatic void model(input int kk, output logic [6:0] s,
                                output logic [N-1:0] ds, output logic fd);
    int             f, slot, sub;
    logic [4*N-1:0] d;
    logic [N-1:0]   e, b;
    bit             lit_phase;
    f    = kk / FRAME;
    slot = (kk / SD) % N;
    sub  = kk % SD;
    d = '0;
    e = '0;
    b = '0;
    foreach (loads[i]) begin
      if (loads[i].cyc < f * FRAME) begin
        d = loads[i].d;
        e = loads[i].e;
        b = loads[i].b;
      end
    end
    lit_phase = ((f / BF) % 2) == 0;
    fd = (kk > 0) && (kk % FRAME == 0);
    s  = 7'h00;
    ds = '0;
    if (sub != 0) begin
      ds[slot] = 1'b1;
      if (e[slot] && !(b[slot] && !lit_phase)) s = glyph(int'(d[slot*4 +: 4]));
    end
  endfunction

  task automatic check_outputs();
    logic [6:0]   s;
    logic [N-1:0] ds;
    logic         fd;
    model(k, s, ds, fd);
    check($sformatf("seg k=%0d", k), 32'(seg), 32'(s));
    check($sformatf("dig_sel k=%0d", k), 32'(dig_sel), 32'(ds));
    check($sformatf("frame_done k=%0d", k), 32'(frame_done), 32'(fd));
  endtask

  task automatic check_blank(input string tag);
    check({tag, " seg"}, 32'(seg), 32'h0);
    check({tag, " dig_sel"}, 32'(dig_sel), 32'h0);
    check({tag, " frame_done"}, 32'(frame_done), 32'h0);
  endtask

  // Called at a falling edge: check cycle k, drive this cycle's inputs, advance.
  task automatic cycle(input bit ld, input logic [4*N-1:0] d,
                       input logic [N-1:0] e, input logic [N-1:0] b);
    check_outputs();
    load      = ld;
    digits_in = d;
    ena_in    = e;
    blink_in  = b;
    if (ld) loads.push_back(load_rec_t'{k, d, e, b});
    @(posedge clk);
    k++;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Idle cycles with junk on the data inputs, which must be ignored without load.
  task automatic idle_to(input int target);
    while (k < target) cycle(1'b0, rnd_d(), rnd_m(), rnd_m());
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    k         = 0;
    load      = 1'b0;
    digits_in = '0;
    ena_in    = '0;
    blink_in  = '0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    check_blank("in reset");
    rst_n = 1'b1;

    // Frame 0 stays dark; 012345 becomes visible in frame 1 as 6D,66,4F,5B,06,3F.
    idle_to(2);
    cycle(1'b1, 24'h012345, 6'h3F, 6'h00);

    // Load in digit 3 of frame 1: old data for the rest of frame 1, new in frame 2.
    idle_to(FRAME + 3*SD + 1);
    cycle(1'b1, rnd_d(), 6'h3F, 6'h00);

    // Two loads in frame 2: only the second commits at frame 3.
    idle_to(2*FRAME + 2);
    cycle(1'b1, rnd_d(), rnd_m(), rnd_m());
    idle_to(2*FRAME + 15);
    cycle(1'b1, rnd_d(), rnd_m(), 6'h00);

    // Load on the frame-wrap cycle: shown in frame 4. Digit 2 carries nibble C.
    idle_to(4*FRAME - 1);
    cycle(1'b1, 24'h98AC07, 6'h3F, 6'h00);

    // Blink on digit 0: lit in frames 4-5 and 8-9, dark in 6-7 and 10-11.
    idle_to(4*FRAME + 5);
    cycle(1'b1, 24'h012345, 6'h3F, 6'h01);
    idle_to(12*FRAME);

    // Random loads at random cycles.
    while (k < 22*FRAME) begin
      if ($urandom_range(15) == 0) cycle(1'b1, rnd_d(), rnd_m(), rnd_m());
      else                         cycle(1'b0, rnd_d(), rnd_m(), rnd_m());
    end

    // All-8s committed at frame 23, then a pending-only load that reset must discard.
    cycle(1'b1, 24'h888888, 6'h3F, 6'h00);
    idle_to(23*FRAME + 1);
    cycle(1'b1, rnd_d(), 6'h3F, 6'h00);
    idle_to(23*FRAME + 2*SD + 2);
    check_outputs();
    check("lit before reset", 32'(seg), 32'h7F);

    // Asynchronous reset mid-slot.
    #2 rst_n = 1'b0;
    #1 check_blank("reset immediate");
    @(negedge clk);
    @(negedge clk);
    check_blank("reset held");
    rst_n = 1'b1;
    k     = 0;
    loads.delete();

    // Scan restarts at digit 0, stays dark (pending discarded) until a new load.
    idle_to(FRAME + 3);
    cycle(1'b1, 24'h765432, 6'h3F, 6'h00);
    idle_to(3*FRAME);
    check_outputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
